// File: rtl/montgomery_pkg.sv
// Shared constants and state encoding for the Montgomery modular-exponentiation sequencer.
// All arithmetic is modulo the fixed 64-bit modulus N; R = 2^64.
package montgomery_pkg;

  localparam logic [63:0] N       = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] N_INV   = 64'hEEEE_EEEE_EEEE_EEEF;
  localparam logic [63:0] R2      = 64'h0000_0000_0000_00E1;
  localparam logic [63:0] ONE_BAR = 64'h0000_0000_0000_000F;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    CONV_IN,
    LOOP,
    CONV_OUT,
    DONE
  } modexp_state_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
  } mul_req_t;

endpackage

// File: rtl/modexp_tag_fifo.sv
// Two-entry in-order FIFO of 1-bit tags recording whether each in-flight engine op was a MUL or a SQR.
// Push and pop may occur in the same cycle, including when full.
module modexp_tag_fifo (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic empty,
  output logic full
);

  logic [1:0] mem;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);

endmodule

// File: rtl/montgomery_modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for base^exp mod N over one shared Montgomery engine.
// Domain conversion in and out also runs on the engine; MUL and SQR of an iteration overlap in its pipeline.
module montgomery_modexp_ctrl
  import montgomery_pkg::*;
#(
  parameter int EXP_W     = 64,
  parameter int DRAIN_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      base,
  input  logic [EXP_W-1:0] exp,
  input  logic             taken,
  output logic             ready_in,
  output logic [63:0]      result,
  output logic             ready_out,
  input  logic             given,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  output logic             mul_taken,
  input  logic             mul_ready_in,
  input  logic [63:0]      mul_out,
  input  logic             mul_ready_out,
  output logic             mul_given
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  modexp_state_t    state, state_nx;
  logic [CNT_W-1:0] drain_cnt;
  logic [EXP_W-1:0] e_sh;
  logic [EXP_W-1:0] e_sh_nx;
  logic [63:0]      b_bar;
  logic [63:0]      r_bar;
  logic             cv_pend;
  logic             mul_done;
  logic             sqr_done;

  logic             issue_pending;
  logic             mul_given_c;
  logic             res_ok;
  logic             iter_end;
  mul_req_t         op;

  logic             tag_push;
  logic             tag_pop;
  logic             tag_out;
  logic             tag_empty;
  logic             tag_full;

  assign e_sh_nx  = e_sh >> 1;
  // conversion results only count once the single conversion op has left the issue stage
  assign res_ok   = mul_ready_out && !cv_pend;
  assign iter_end = tag_empty && mul_done && sqr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DRAIN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    ready_in      = 1'b0;
    ready_out     = 1'b0;
    issue_pending = 1'b0;
    mul_given_c   = 1'b0;
    op            = '{a: b_bar, b: b_bar};
    case (state)
      DRAIN: begin
        mul_given_c = mul_ready_out;
        if (drain_cnt == CNT_W'(DRAIN_CYC - 1)) state_nx = IDLE;
      end
      IDLE: begin
        ready_in = 1'b1;
        if (taken) state_nx = CONV_IN;
      end
      CONV_IN: begin
        issue_pending = cv_pend;
        op            = '{a: b_bar, b: R2};
        mul_given_c   = mul_ready_out;
        if (res_ok) state_nx = (e_sh != '0) ? LOOP : CONV_OUT;
      end
      LOOP: begin
        issue_pending = !mul_done || !sqr_done;
        op            = !mul_done ? '{a: r_bar, b: b_bar} : '{a: b_bar, b: b_bar};
        mul_given_c   = mul_ready_out;
        if (iter_end && e_sh_nx == '0) state_nx = CONV_OUT;
      end
      CONV_OUT: begin
        issue_pending = cv_pend;
        op            = '{a: r_bar, b: 64'd1};
        mul_given_c   = mul_ready_out;
        if (res_ok) state_nx = DONE;
      end
      DONE: begin
        ready_out = 1'b1;
        if (given) state_nx = IDLE;
      end
      default: state_nx = DRAIN;
    endcase
  end

  assign mul_a     = op.a;
  assign mul_b     = op.b;
  assign mul_taken = issue_pending && mul_ready_in;
  assign mul_given = mul_given_c && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
      e_sh      <= '0;
      b_bar     <= '0;
      r_bar     <= '0;
      result    <= '0;
      cv_pend   <= 1'b0;
      mul_done  <= 1'b1;
      sqr_done  <= 1'b1;
    end else begin
      if (mul_taken) cv_pend <= 1'b0;
      case (state)
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        IDLE: begin
          if (taken) begin
            b_bar   <= base;
            e_sh    <= exp;
            r_bar   <= ONE_BAR;
            cv_pend <= 1'b1;
          end
        end
        CONV_IN: begin
          if (res_ok) begin
            b_bar    <= mul_out;
            mul_done <= ~e_sh[0];
            sqr_done <= (e_sh_nx == '0);
            if (e_sh == '0) cv_pend <= 1'b1;
          end
        end
        LOOP: begin
          if (mul_taken) begin
            if (!mul_done) mul_done <= 1'b1;
            else           sqr_done <= 1'b1;
          end
          // both ops of an iteration read the old b_bar; SQR is issued before any result lands
          if (mul_ready_out && !tag_empty) begin
            if (tag_out) r_bar <= mul_out;
            else         b_bar <= mul_out;
          end
          if (iter_end) begin
            e_sh     <= e_sh_nx;
            mul_done <= ~e_sh_nx[0];
            sqr_done <= ((e_sh_nx >> 1) == '0);
            if (e_sh_nx == '0) cv_pend <= 1'b1;
          end
        end
        CONV_OUT: if (res_ok) result <= mul_out;
        default: ;
      endcase
    end
  end

  assign tag_push = (state == LOOP) && mul_taken;
  assign tag_pop  = (state == LOOP) && mul_ready_out;

  modexp_tag_fifo u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (!mul_done),
    .pop   (tag_pop),
    .dout  (tag_out),
    .empty (tag_empty),
    .full  (tag_full)
  );

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// Bench for montgomery_modexp_ctrl: behavioural Montgomery engine plus a plain modexp reference model.
module tb_montgomery_modexp_ctrl;
  import montgomery_pkg::*;

  localparam int EXP_W     = 64;
  localparam int DRAIN_CYC = 16;
  localparam int LAT       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      base;
  logic [EXP_W-1:0] exp;
  logic             taken;
  logic             ready_in;
  logic [63:0]      result;
  logic             ready_out;
  logic             given;
  logic [63:0]      mul_a, mul_b;
  logic             mul_taken;
  logic             mul_ready_in;
  logic [63:0]      mul_out;
  logic             mul_ready_out;
  logic             mul_given;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] v;
    int          t;
  } eng_t;
  eng_t eq[$];
  int   cyc       = 0;
  int   issue_cnt = 0;
  bit   bp        = 1'b0;

  montgomery_modexp_ctrl #(.EXP_W(EXP_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .base(base), .exp(exp), .taken(taken),
    .ready_in(ready_in), .result(result), .ready_out(ready_out), .given(given),
    .mul_a(mul_a), .mul_b(mul_b), .mul_taken(mul_taken), .mul_ready_in(mul_ready_in),
    .mul_out(mul_out), .mul_ready_out(mul_ready_out), .mul_given(mul_given)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // a*b*R^-1 mod N
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b);
    logic [129:0] t, u;
    logic [63:0]  m;
    t = {66'd0, a} * {66'd0, b};
    m = t[63:0] * N_INV;
    u = (t + {66'd0, m} * {66'd0, N}) >> 64;
    return 64'(u % {66'd0, N});
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, N});
  endfunction

  function automatic logic [63:0] modexp_ref(input logic [63:0] b, input logic [63:0] e);
    logic [63:0] r, x;
    r = 64'd1;
    x = (b >= N) ? b - N : b;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = mulmod(r, x);
      x = mulmod(x, x);
    end
    return r;
  endfunction

  function automatic int ops_ref(input logic [63:0] e);
    int bl;
    bl = 0;
    for (int i = 0; i < 64; i++) if (e[i]) bl = i + 1;
    return 2 + $countones(e) + ((bl > 0) ? bl - 1 : 0);
  endfunction

  // engine: in-order pipeline of LAT cycles, handshake sampled mid-cycle, applied just after the edge
  initial begin
    logic tk, gv, ro;
    logic [63:0] a, b;
    mul_ready_in  = 1'b1;
    mul_ready_out = 1'b0;
    mul_out       = '0;
    forever begin
      @(negedge clk);
      tk = mul_taken; gv = mul_given; ro = mul_ready_out; a = mul_a; b = mul_b;
      @(posedge clk);
      #1;
      cyc++;
      if (gv && ro && eq.size() > 0) eq.delete(0);
      if (tk) begin
        eq.push_back('{v: mont(a, b), t: cyc + LAT - 1});
        issue_cnt++;
      end
      mul_ready_out = (eq.size() > 0) && (eq[0].t <= cyc);
      mul_out       = (eq.size() > 0) ? eq[0].v : '0;
      mul_ready_in  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready_in"},  64'(ready_in),  64'd0);
    chk({tag, "_ready_out"}, 64'(ready_out), 64'd0);
    chk({tag, "_mul_taken"}, 64'(mul_taken), 64'd0);
    chk({tag, "_mul_given"}, 64'(mul_given), 64'd0);
    chk({tag, "_result"},    result,         64'd0);
  endtask

  // call right after reset release (just past a rising edge); returns on a falling edge
  task automatic drain_check(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!ready_in && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_len"}, 64'(cnt), 64'(DRAIN_CYC));
  endtask

  // call on a falling edge; returns on a falling edge with the controller idle
  task automatic run_req(input logic [63:0] b, input logic [63:0] e, input bit bp_mode, input int hold);
    int          n, ops0;
    bit          rin_seen;
    logic [63:0] want;
    bp = bp_mode;
    n  = 0;
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready_in", 64'(ready_in), 64'd1);
    ops0  = issue_cnt;
    base  = b;
    exp   = e;
    taken = 1'b1;
    @(posedge clk);
    #1;
    taken = 1'b0;
    base  = {32'($urandom), 32'($urandom)};
    exp   = {32'($urandom), 32'($urandom)};
    rin_seen = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 20000) begin
      if (ready_in) rin_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    want = modexp_ref(b, e);
    chk("done_timeout", 64'(ready_out), 64'd1);
    chk("busy_ready_in", 64'(rin_seen), 64'd0);
    chk("result", result, want);
    chk("ops", 64'(issue_cnt - ops0), 64'(ops_ref(e)));
    for (int i = 0; i < hold; i++) begin
      taken = 1'b1;
      base  = {32'($urandom), 32'($urandom)};
      exp   = 64'($urandom_range(1, 255));
      @(negedge clk);
      chk("hold_result", result, want);
      chk("hold_ready_in", 64'(ready_in), 64'd0);
      chk("hold_ready_out", 64'(ready_out), 64'd1);
    end
    taken = 1'b0;
    given = 1'b1;
    chk("given_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;
    given = 1'b0;
    @(negedge clk);
    chk("idle_ready_in", 64'(ready_in), 64'd1);
    chk("idle_ready_out", 64'(ready_out), 64'd0);
    bp = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; taken = 1'b0; given = 1'b0; base = '0; exp = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    drain_check("drain");

    run_req(64'd2, 64'd10, 1'b0, 0);
    run_req(64'd5, 64'd0, 1'b0, 0);
    run_req(64'hFFFF_FFFF_FFFF_FFF4, 64'd2, 1'b0, 0);
    run_req(64'd2, 64'd64, 1'b0, 0);
    run_req(64'd0, 64'd7, 1'b0, 0);
    run_req(N, 64'd3, 1'b0, 0);
    run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

    // backpressure on the engine, consumer stalls while junk requests are offered
    run_req({32'($urandom), 32'($urandom)}, 64'($urandom_range(1, 4095)), 1'b1, 20);

    for (int i = 0; i < 8; i++) begin
      logic [63:0] rb, re;
      rb = {32'($urandom), 32'($urandom)};
      if (i == 3) rb = N + 64'($urandom_range(0, 14));
      re = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
      run_req(rb, re, i[0], (i == 5) ? 3 : 0);
    end

    // reset while MUL and SQR are both in the engine
    base  = {32'($urandom), 32'($urandom)};
    exp   = 64'hFF;
    taken = 1'b1;
    @(posedge clk);
    #1 taken = 1'b0;
    n = 0;
    while (eq.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("inflight", 64'(eq.size()), 64'd2);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    chk_reset_vals("midrst_hold");
    @(posedge clk);
    #1 rst = 1'b0;
    drain_check("redrain");
    chk("stale_flushed", 64'(eq.size()), 64'd0);
    run_req(64'd3, 64'd5, 1'b0, 0);
    chk("ref_243", modexp_ref(64'd3, 64'd5), 64'd243);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
